// File: rtl/hex_pkg.sv
// Shared constants and encodings for the hex digit counter and its rate divider.
package hex_pkg;

   localparam int DIGIT_W = 4;

   localparam logic [DIGIT_W-1:0] HEX_MAX = 4'hF;
   localparam logic [DIGIT_W-1:0] HEX_MIN = 4'h0;

   typedef enum logic [1:0] {
      RATE_FULL    = 2'd0,
      RATE_HALF    = 2'd1,
      RATE_QUARTER = 2'd2,
      RATE_EVERY   = 2'd3
   } rate_sel_e;

endpackage

// File: rtl/hex_digit_counter_if.sv
// Control and digit-output bundle between a display controller and the hex digit counter.
interface hex_digit_counter_if;
   import hex_pkg::*;

   logic               enable;
   logic               load;
   logic [DIGIT_W-1:0] load_value;
   logic               up;
   logic [1:0]         rate_sel;
   logic               c0;
   logic               c1;
   logic               c2;
   logic               c3;
   logic               tick;
   logic               wrap;

   modport master (
      output enable, load, load_value, up, rate_sel,
      input  c0, c1, c2, c3, tick, wrap
   );

   modport slave (
      input  enable, load, load_value, up, rate_sel,
      output c0, c1, c2, c3, tick, wrap
   );

endinterface

// File: rtl/rate_divider.sv
// Enabled cycle counter; flags an advance once the count reaches or passes the limit.
module rate_divider #(
   parameter int DIV_W = 26
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             clear,
   input  logic [DIV_W-1:0] limit,
   output logic             advance
);

   logic [DIV_W-1:0] count;
   logic             at_limit;

   // >= rather than == so a lowered limit fires at once instead of wrapping the counter
   assign at_limit = (count >= limit);
   assign advance  = enable && !clear && at_limit;

   always_ff @(posedge clock) begin
      if (reset || clear) begin
         count <= '0;
      end else if (enable) begin
         if (at_limit) count <= '0;
         else          count <= count + DIV_W'(1);
      end
   end

endmodule

// File: rtl/hex_digit_counter.sv
// Rate-divided 4-bit up/down digit with parallel load and registered tick/wrap pulses.
module hex_digit_counter
   import hex_pkg::*;
#(
   parameter int DIV_MAX = 49_999_999,
   parameter int DIV_W   = 26
) (
   input  logic                clock,
   input  logic                reset,
   hex_digit_counter_if.slave  bus
);

   localparam logic [DIV_W-1:0] LIM_FULL    = DIV_W'(DIV_MAX);
   localparam logic [DIV_W-1:0] LIM_HALF    = DIV_W'(DIV_MAX >> 1);
   localparam logic [DIV_W-1:0] LIM_QUARTER = DIV_W'(DIV_MAX >> 2);

   logic [DIV_W-1:0]   limit;
   logic               advance;
   logic [DIGIT_W-1:0] digit;
   logic               tick_q;
   logic               wrap_q;

   always_comb begin
      limit = LIM_FULL;
      case (rate_sel_e'(bus.rate_sel))
         RATE_FULL:    limit = LIM_FULL;
         RATE_HALF:    limit = LIM_HALF;
         RATE_QUARTER: limit = LIM_QUARTER;
         RATE_EVERY:   limit = '0;
         default:      limit = LIM_FULL;
      endcase
   end

   rate_divider #(.DIV_W(DIV_W)) u_div (
      .clock   (clock),
      .reset   (reset),
      .enable  (bus.enable),
      .clear   (bus.load),
      .limit   (limit),
      .advance (advance)
   );

   // advance is already gated by load, so load wins over counting here
   always_ff @(posedge clock) begin
      if (reset) begin
         digit  <= HEX_MIN;
         tick_q <= 1'b0;
         wrap_q <= 1'b0;
      end else if (bus.load) begin
         digit  <= bus.load_value;
         tick_q <= 1'b0;
         wrap_q <= 1'b0;
      end else if (advance) begin
         digit  <= bus.up ? digit + DIGIT_W'(1) : digit - DIGIT_W'(1);
         tick_q <= 1'b1;
         wrap_q <= bus.up ? (digit == HEX_MAX) : (digit == HEX_MIN);
      end else begin
         tick_q <= 1'b0;
         wrap_q <= 1'b0;
      end
   end

   assign bus.c0   = digit[0];
   assign bus.c1   = digit[1];
   assign bus.c2   = digit[2];
   assign bus.c3   = digit[3];
   assign bus.tick = tick_q;
   assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_hex_digit_counter.sv
// Scoreboard bench for hex_digit_counter: directed scenarios then random traffic vs a cycle model.
module tb_hex_digit_counter;

   localparam int DIV_MAX = 7;
   localparam int DIV_W   = 26;

   logic clk = 1'b0;
   logic rst = 1'b1;

   hex_digit_counter_if dif ();

   hex_digit_counter #(.DIV_MAX(DIV_MAX), .DIV_W(DIV_W)) dut (
      .clock (clk),
      .reset (rst),
      .bus   (dif)
   );

   always #5 clk = ~clk;

   // Expected {digit[3:0], tick, wrap} after each edge
   logic [5:0] exp_q[$];
   int         tests  = 0;
   int         errors = 0;
   int         cyc    = 0;

   // Reference model state: digit value and enabled cycles elapsed in the current period
   int m_digit   = 0;
   int m_elapsed = 0;
   bit m_tick    = 0;
   bit m_wrap    = 0;

   function automatic int period_limit(input int rs);
      case (rs)
         0: return DIV_MAX;
         1: return DIV_MAX / 2;
         2: return DIV_MAX / 4;
         default: return 0;
      endcase
   endfunction

   task automatic drive(input bit r, input bit en, input bit ld, input int lv,
                        input bit u, input int rs);
      @(negedge clk);
      rst            = r;
      dif.enable     = en;
      dif.load       = ld;
      dif.load_value = 4'(lv);
      dif.up         = u;
      dif.rate_sel   = 2'(rs);
      @(posedge clk);
      cyc++;
      if (r) begin
         m_digit = 0; m_elapsed = 0; m_tick = 0; m_wrap = 0;
      end else if (ld) begin
         m_digit = lv % 16; m_elapsed = 0; m_tick = 0; m_wrap = 0;
      end else if (en) begin
         if (m_elapsed >= period_limit(rs)) begin
            m_wrap    = u ? (m_digit == 15) : (m_digit == 0);
            m_digit   = u ? (m_digit + 1) % 16 : (m_digit + 15) % 16;
            m_elapsed = 0;
            m_tick    = 1;
         end else begin
            m_elapsed++;
            m_tick = 0; m_wrap = 0;
         end
      end else begin
         m_tick = 0; m_wrap = 0;
      end
      exp_q.push_back({4'(m_digit), m_tick, m_wrap});
   endtask

   task automatic run(input int n, input bit en, input bit u, input int rs);
      for (int i = 0; i < n; i++) drive(0, en, 0, 0, u, rs);
   endtask

   // Monitor: outputs are registered, so every edge yields one observation
   logic [5:0] mon_exp, mon_got;
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         mon_exp = exp_q.pop_front();
         mon_got = {dif.c3, dif.c2, dif.c1, dif.c0, dif.tick, dif.wrap};
         tests++;
         if (mon_got !== mon_exp) begin
            errors++;
            $display("FAIL out_check cyc=%0d got digit=%h tick=%b wrap=%b expected digit=%h tick=%b wrap=%b",
                     cyc, mon_got[5:2], mon_got[1], mon_got[0],
                     mon_exp[5:2], mon_exp[1], mon_exp[0]);
         end
      end
   end

   initial begin
      int rs_r;
      dif.enable = 0; dif.load = 0; dif.load_value = 0; dif.up = 1; dif.rate_sel = 0;

      // Reset two cycles, then count up at full divide
      drive(1, 1, 0, 0, 1, 0);
      drive(1, 1, 0, 0, 1, 0);
      run(24, 1, 1, 0);

      // Load E, fast count up through the F->0 wrap
      drive(0, 1, 1, 14, 1, 3);
      run(4, 1, 1, 3);

      // Down from 0 wraps to F, then E
      drive(0, 0, 1, 0, 0, 3);
      run(2, 1, 0, 3);

      // Lowered limit below current divider progress fires on next enabled edge
      drive(0, 0, 1, 3, 1, 0);
      run(5, 1, 1, 0);
      run(7, 1, 1, 2);

      // Load together with enable at divider == limit: load wins, period restarts
      drive(0, 0, 1, 9, 1, 0);
      run(7, 1, 1, 0);
      drive(0, 1, 1, 5, 1, 0);
      run(10, 1, 1, 0);

      // Freeze mid-period, resume, then reset mid-period
      run(3, 1, 0, 0);
      run(10, 0, 0, 0);
      run(7, 1, 0, 0);
      run(3, 1, 0, 0);
      drive(1, 1, 0, 0, 0, 0);
      run(9, 1, 1, 0);

      // Random traffic
      rs_r = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0) rs_r = int'($urandom_range(0, 3));
         drive($urandom_range(0, 99) == 0,
               $urandom_range(0, 3) != 0,
               $urandom_range(0, 15) == 0,
               int'($urandom_range(0, 15)),
               $urandom_range(0, 3) != 0,
               rs_r);
      end

      @(negedge clk);
      @(negedge clk);
      tests++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d pending expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule

// File: doc/hex_digit_counter.md
Name: hex_digit_counter

Overview:
- Rate-divided 4-bit up/down counter that generates the hex digit driving the segment decoders (H0..H6).
- Outputs are individual bits c0..c3, so each decoder's c0..c3 inputs connect directly.
- Supports parallel load, enable, a selectable advance rate, and single-cycle tick/wrap pulses for chaining multi-digit displays.

Parameters:
- DIV_MAX, 49_999_999, terminal count of the rate divider; default gives 1 advance/s at 50 MHz.
- DIV_W, 26, divider register width; must satisfy 2^DIV_W > DIV_MAX.

Ports:
- clock  input  1  single system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  1 = divider runs and digit may advance; 0 = all state holds.
- load  input  1  1 = load load_value on the next edge.
- load_value  input  4  value loaded into the digit.
- up  input  1  1 = count up, 0 = count down.
- rate_sel  input  2  divider limit: 0 → DIV_MAX, 1 → DIV_MAX>>1, 2 → DIV_MAX>>2, 3 → 0 (advance every enabled cycle).
- c0  output  1  digit bit 0 (LSB).
- c1  output  1  digit bit 1.
- c2  output  1  digit bit 2.
- c3  output  1  digit bit 3 (MSB).
- tick  output  1  one-cycle pulse, high in the first cycle the new digit is visible.
- wrap  output  1  one-cycle pulse with tick when the digit went F→0 (up) or 0→F (down).

Behaviour:
- Reset (synchronous, highest priority):
  - digit = 0, divider = 0, tick = 0, wrap = 0.
  - c3..c0 = 0000 in the cycle after the reset edge.
- Priority per edge: reset > load > enable/count > hold.
- Load:
  - digit ← load_value and divider ← 0.
  - tick = 0, wrap = 0; no advance that edge, even if enable = 1.
- Enable = 0 and no load: digit and divider hold; tick = 0, wrap = 0.
- Enable = 1 and no load:
  - If divider >= limit(rate_sel): divider ← 0, digit ← digit ± 1 (mod 16, direction per `up` sampled that edge), tick ← 1.
  - Otherwise: divider ← divider + 1, tick ← 0.
- The comparison is >=. If rate_sel lowers the limit below the current divider value, the digit advances on the next enabled edge; no long wrap-around of the divider.
- Advance period is limit+1 enabled cycles, measured from reset, load, or the previous advance. rate_sel = 3 advances every enabled cycle.
- Wrap:
  - wrap ← 1 on an advance where (up = 1 and digit = F) or (up = 0 and digit = 0).
  - wrap is always a subset of tick.
- Outputs are registered: the digit update, tick and wrap all become visible one cycle after the qualifying edge's inputs; no combinational input-to-output path.
- Direction reversal mid-period does not reset the divider; it only affects the next advance.
- Reset asserted mid-period discards divider progress. A pending advance is cancelled.
- Width rules:
  - Digit arithmetic is 4-bit modulo.
  - Divider is DIV_W bits unsigned.
  - The limit shifts are logical right shifts of DIV_MAX, truncating.

Decomposition:
- Shared package hex_pkg:
  - DIGIT_W = 4.
  - rate_sel encodings RATE_FULL = 0, RATE_HALF = 1, RATE_QUARTER = 2, RATE_EVERY = 3.
  - Constants HEX_MAX = 4'hF and HEX_MIN = 4'h0.
- Sub-module rate_divider (clock, reset, enable, clear, limit[DIV_W-1:0] → advance):
  - Contains the divider register and the >= compare.
  - hex_digit_counter owns the digit register, load mux, and tick/wrap registers.

Test Plan (DIV_MAX = 7 for simulation):
- Reset held 2 cycles, then enable = 1, up = 1, rate_sel = 0 → c3..c0 = 0000; first tick 8 cycles after reset release with digit = 1; tick high exactly 1 cycle per 8.
- load = 1, load_value = E; then enable, up = 1, rate_sel = 3 → digits E, F, 0, 1 on consecutive cycles; wrap = 1 only in the cycle showing 0, together with tick.
- digit = 0, up = 0, rate_sel = 3 → next digit F with wrap = 1; then E with wrap = 0.
- rate_sel = 0, divider at 5, switch rate_sel to 2 (limit 1) → advance on the next enabled edge (5 >= 1), then every 2 cycles.
- Load and enable both asserted at divider = limit → digit = load_value, tick = 0; next advance occurs 8 enabled cycles later.
- enable = 0 for 10 cycles mid-period → digit and tick hold; on re-enable the advance completes after the remaining cycles. Then reset asserted mid-period → digit = 0 on the next edge and no tick.
